avalon_mm_32to16_adapter: RTL

//  Bridges a 32-bit Avalon-MM master (Nios II data port) to one 16-bit halfword-register slave
//  (interval timer, PWM and encoder blocks): each 32-bit word access becomes up to two

---
 rtl/avalon_pkg.sv | 19 +
 rtl/avalon_mm_32to16_adapter_if.sv | 34 +++
 rtl/avalon_mm_32to16_adapter_read_tag_pipe.sv | 43 ++++
 rtl/avalon_mm_32to16_adapter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared definitions for the 32-to-16-bit Avalon-MM adapter: FSM states and limits.
package avalon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        DRAIN,
        DONE
    } state_t;

    localparam int READ_LAT_MAX = 4;

    // A half is accessed when any of its two byte lanes is enabled.
    function automatic logic half_en(input logic [3:0] be, input logic hi);
        return hi ? (|be[3:2]) : (|be[1:0]);
    endfunction

endpackage

// File: rtl/avalon_mm_32to16_adapter_if.sv
// Bundle of the 32-bit master-side and 16-bit slave-side Avalon-MM signals.
interface avalon_mm_32to16_adapter_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              m_waitrequest;
    logic [ADDR_W:0]   s_address;
    logic              s_chipselect;
    logic              s_write_n;
    logic [15:0]       s_writedata;
    logic [15:0]       s_readdata;

    modport master (
        output m_address, m_read, m_write, m_byteenable, m_writedata,
        input  m_readdata, m_waitrequest
    );

    modport slave (
        input  s_address, s_chipselect, s_write_n, s_writedata,
        output s_readdata
    );

    modport bridge (
        input  m_address, m_read, m_write, m_byteenable, m_writedata,
        output m_readdata, m_waitrequest,
        output s_address, s_chipselect, s_write_n, s_writedata,
        input  s_readdata
    );
endinterface

// File: rtl/avalon_mm_32to16_adapter_read_tag_pipe.sv
// READ_LAT-deep shift pipe of {valid,half} tags; the last stage lines up with slave readdata.
module read_tag_pipe #(
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_valid_i,
    input  logic push_half_i,
    output logic pop_valid_o,
    output logic pop_half_o,
    output logic pending_o
);
    logic [READ_LAT-1:0] valid_q, valid_d;
    logic [READ_LAT-1:0] half_q, half_d;
    logic [READ_LAT-1:0] younger;

    for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign valid_d[gi] = push_valid_i;
            assign half_d[gi]  = push_half_i;
        end else begin : g_tail
            assign valid_d[gi] = valid_q[gi-1];
            assign half_d[gi]  = half_q[gi-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            half_q  <= '0;
        end else begin
            valid_q <= valid_d;
            half_q  <= half_d;
        end
    end

    // Tags still in flight behind the one emerging this cycle.
    assign younger     = valid_q << 1;
    assign pending_o   = |younger;
    assign pop_valid_o = valid_q[READ_LAT-1];
    assign pop_half_o  = half_q[READ_LAT-1];

endmodule

// File: rtl/avalon_mm_32to16_adapter.sv
// Splits each 32-bit Avalon-MM word access into up to two 16-bit slave accesses, low half first.
module avalon_mm_32to16_adapter
    import avalon_pkg::*;
#(
    parameter int ADDR_W   = 2,
    parameter int READ_LAT = 1
) (
    input logic                         clk,
    input logic                         reset_n,
    avalon_mm_32to16_adapter_if.bridge  bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wd_q, wd_d;
    logic              wr_q, wr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              wait_q, wait_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic [ADDR_W:0]   saddr_q, saddr_d;
    logic [15:0]       swd_q, swd_d;
    logic              strobe_hi;
    logic              strobe;
    logic              tag_pop_valid;
    logic              tag_pop_half;
    logic              tag_pending;

    read_tag_pipe #(
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_valid_i (cs_q & wn_q),
        .push_half_i  (saddr_q[0]),
        .pop_valid_o  (tag_pop_valid),
        .pop_half_o   (tag_pop_half),
        .pending_o    (tag_pending)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.m_write || bus.m_read) begin
                    addr_d  = bus.m_address;
                    be_d    = bus.m_byteenable;
                    wd_d    = bus.m_writedata;
                    wr_d    = bus.m_write;
                    rdata_d = '0;
                    if (half_en(bus.m_byteenable, 1'b0))      state_d = ISSUE_LO;
                    else if (half_en(bus.m_byteenable, 1'b1)) state_d = ISSUE_HI;
                    else                                      state_d = DONE;
                end
            end
            ISSUE_LO: begin
                if (half_en(be_q, 1'b1)) state_d = ISSUE_HI;
                else                     state_d = wr_q ? DONE : DRAIN;
            end
            ISSUE_HI: state_d = wr_q ? DONE : DRAIN;
            DRAIN:    if (!tag_pending) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (tag_pop_valid) begin
            if (tag_pop_half) rdata_d[31:16] = bus.s_readdata;
            else              rdata_d[15:0]  = bus.s_readdata;
        end

        // Slave strobes are registered, so they are decoded from the next state.
        strobe_hi = (state_d == ISSUE_HI);
        strobe    = ((state_d == ISSUE_LO) || strobe_hi) && half_en(be_d, strobe_hi);
        cs_d      = strobe;
        wn_d      = !(strobe && wr_d);
        saddr_d   = strobe ? {addr_d, strobe_hi} : saddr_q;
        swd_d     = strobe ? (strobe_hi ? wd_d[31:16] : wd_d[15:0]) : swd_q;
        wait_d    = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            wait_q  <= 1'b1;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            saddr_q <= '0;
            swd_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            saddr_q <= saddr_d;
            swd_q   <= swd_d;
        end
    end

    assign bus.m_readdata    = rdata_q;
    assign bus.m_waitrequest = wait_q;
    assign bus.s_address     = saddr_q;
    assign bus.s_chipselect  = cs_q;
    assign bus.s_write_n     = wn_q;
    assign bus.s_writedata   = swd_q;

endmodule
